iram_arbiter: RTL and testbench

IRAM_ARBITER -- requirements
Module: iram_arbiter

---
 rtl/iram_arbiter_if.sv | 27 ++
 rtl/iram_arbiter.sv | 116 +++++++++++
 tb/tb_iram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iram_arbiter_if.sv
// Bus between the fetching cores, the shared instruction RAM and the arbiter.
// The master side plays the cores plus RAM; the arbiter uses the slave side.
interface iram_arbiter_if #(
  parameter int unsigned NCORES = 4,
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16
);
  logic [NCORES-1:0]    req;
  logic [NCORES-1:0]    lock;
  logic [NCORES*AW-1:0] addr;
  logic [NCORES-1:0]    gnt;
  logic [AW-1:0]        ram_addr;
  logic [DW-1:0]        ram_data;
  logic [NCORES-1:0]    rvalid;
  logic [DW-1:0]        rdata;
  logic [15:0]          fetch_count;

  modport master (
    output req, lock, addr, ram_data,
    input  gnt, ram_addr, rvalid, rdata, fetch_count
  );

  modport slave (
    input  req, lock, addr, ram_data,
    output gnt, ram_addr, rvalid, rdata, fetch_count
  );
endinterface

// File: rtl/iram_arbiter.sv
// Round-robin arbiter sharing one instruction RAM between NCORES cores, with a
// bounded lock so a core can fetch a multi-word instruction without interleaving.
module iram_arbiter #(
  parameter int unsigned NCORES   = 4,
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned LOCK_MAX = 4
) (
  input logic           clk,
  input logic           reset,
  iram_arbiter_if.slave bus
);

  localparam int unsigned PW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {StRotate, StLocked} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NCORES-1:0] rvalid_q;
  logic [AW-1:0]     addr_q;
  logic [15:0]       fetch_count_q;

  logic              grant;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     cand;
  int unsigned       idx;

  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] v);
    return (v == PW'(NCORES - 1)) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    grant   = 1'b0;
    sel     = '0;
    cand    = '0;
    idx     = 0;
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRotate: begin
        for (int unsigned i = 0; i < NCORES; i++) begin
          idx = 32'(ptr_q) + i;
          if (idx >= NCORES) idx = idx - NCORES;
          cand = PW'(idx);
          if (!grant && bus.req[cand]) begin
            grant = 1'b1;
            sel   = cand;
          end
        end
        if (grant) begin
          ptr_d = inc_wrap(sel);
          // With LOCK_MAX of 1 the rotate grant already uses the whole budget.
          if (bus.lock[sel] && (LOCK_MAX > 1)) begin
            state_d = StLocked;
            owner_d = sel;
            cnt_d   = CW'(1);
          end
        end
      end
      StLocked: begin
        if (bus.req[owner_q]) begin
          grant = 1'b1;
          sel   = owner_q;
          if (bus.lock[owner_q] && ((32'(cnt_q) + 1) < LOCK_MAX)) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            state_d = StRotate;
            ptr_d   = inc_wrap(owner_q);
            cnt_d   = '0;
          end
        end else if (!bus.lock[owner_q]) begin
          state_d = StRotate;
          ptr_d   = inc_wrap(owner_q);
          cnt_d   = '0;
        end
      end
      default: state_d = StRotate;
    endcase
    if (reset) grant = 1'b0;
  end

  assign bus.gnt         = grant ? (NCORES'(1) << sel) : '0;
  assign bus.ram_addr    = grant ? bus.addr[32'(sel)*AW +: AW] : addr_q;
  assign bus.rvalid      = rvalid_q;
  assign bus.rdata       = bus.ram_data;
  assign bus.fetch_count = fetch_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StRotate;
      ptr_q         <= '0;
      owner_q       <= '0;
      cnt_q         <= '0;
      rvalid_q      <= '0;
      addr_q        <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rvalid_q <= bus.gnt;
      if (grant) begin
        addr_q <= bus.ram_addr;
        if (fetch_count_q != 16'hFFFF) fetch_count_q <= fetch_count_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_iram_arbiter.sv
// Self-checking bench for iram_arbiter: per-scenario tasks plus a read-data
// scoreboard that matches every predicted grant against rvalid/rdata a cycle later.
module tb_iram_arbiter;
  localparam int unsigned NC = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  typedef struct {
    logic [NC-1:0] gnt;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  iram_arbiter_if #(.NCORES(NC), .AW(AW), .DW(DW)) bus ();

  iram_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int   n_run = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a == 16'd21) ? 16'd64 : (a ^ 16'h5a5a);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.ram_data <= mem_word(bus.ram_addr);

  // Scoreboard: an entry pushed in cycle N must appear on rvalid/rdata in N+1.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        n_run++;
        if (bus.rvalid !== e.gnt) begin
          n_fail++;
          $display("FAIL sb_rvalid cyc=%0d got=%b exp=%b", cyc, bus.rvalid, e.gnt);
        end
        if (e.gnt != '0) begin
          n_run++;
          if (bus.rdata !== e.data) begin
            n_fail++;
            $display("FAIL sb_rdata cyc=%0d got=%h exp=%h", cyc, bus.rdata, e.data);
          end
        end
      end else begin
        n_run++;
        if (bus.rvalid !== '0) begin
          n_fail++;
          $display("FAIL sb_idle_rvalid cyc=%0d got=%b exp=0", cyc, bus.rvalid);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NC-1:0] g, input logic [AW-1:0] a);
    exp_t e;
    e.gnt  = g;
    e.data = mem_word(a);
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    next_cycle();
    reset    = 1'b1;
    bus.req  = '0;
    bus.lock = '0;
    sb.delete();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus.req  = 4'b1111;
    bus.lock = '0;
    bus.addr = {16'd13, 16'd12, 16'd11, 16'd10};
    @(negedge clk);
    n_run += 4;
    if (bus.gnt !== '0) begin
      n_fail++; $display("FAIL reset_gnt got=%b exp=0", bus.gnt);
    end
    if (bus.rvalid !== '0) begin
      n_fail++; $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid);
    end
    if (bus.fetch_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.fetch_count);
    end
    if (bus.ram_addr !== 16'd0) begin
      n_fail++; $display("FAIL reset_ram_addr got=%0d exp=0", bus.ram_addr);
    end
    next_cycle();
    reset   = 1'b0;
    bus.req = '0;
    mon_en  = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] eg;
    logic [AW-1:0] ea;
    do_reset();
    bus.addr = {16'd103, 16'd102, 16'd101, 16'd100};
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      bus.req  = 4'b1111;
      bus.lock = '0;
      @(negedge clk);
      eg = 4'b0001 << (c % 4);
      ea = 16'(100 + (c % 4));
      n_run += 2;
      if (bus.gnt !== eg) begin
        n_fail++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, bus.gnt, eg);
      end
      if (bus.ram_addr !== ea) begin
        n_fail++; $display("FAIL rr_ram_addr c=%0d got=%0d exp=%0d", c, bus.ram_addr, ea);
      end
      push(eg, ea);
    end
    next_cycle();
    bus.req = '0;
    @(negedge clk);
    n_run++;
    if (bus.fetch_count !== 16'd8) begin
      n_fail++; $display("FAIL rr_count got=%0d exp=8", bus.fetch_count);
    end
  endtask

  task automatic test_single_fetch();
    next_cycle();
    bus.req  = 4'b0100;
    bus.addr = {16'd7, 16'd21, 16'd5, 16'd4};
    @(negedge clk);
    n_run += 2;
    if (bus.gnt !== 4'b0100) begin
      n_fail++; $display("FAIL single_gnt got=%b exp=0100", bus.gnt);
    end
    if (bus.ram_addr !== 16'd21) begin
      n_fail++; $display("FAIL single_ram_addr got=%0d exp=21", bus.ram_addr);
    end
    push(4'b0100, 16'd21);
    next_cycle();
    bus.req  = '0;
    bus.addr = {16'd1, 16'd2, 16'd3, 16'd4};
    @(negedge clk);
    n_run++;
    if (bus.ram_addr !== 16'd21) begin
      n_fail++; $display("FAIL hold_ram_addr got=%0d exp=21", bus.ram_addr);
    end
    // A lone requester wins every cycle regardless of the pointer.
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      bus.req = 4'b0010;
      @(negedge clk);
      n_run++;
      if (bus.gnt !== 4'b0010) begin
        n_fail++; $display("FAIL single_repeat c=%0d got=%b exp=0010", c, bus.gnt);
      end
      push(4'b0010, 16'd3);
    end
  endtask

  task automatic test_lock_max();
    logic [NC-1:0] exp_g[5];
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    do_reset();
    bus.addr = {16'd33, 16'd32, 16'd31, 16'd30};
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      bus.req  = 4'b1111;
      bus.lock = 4'b0001;
      @(negedge clk);
      n_run++;
      if (bus.gnt !== exp_g[c]) begin
        n_fail++; $display("FAIL lock_max c=%0d got=%b exp=%b", c, bus.gnt, exp_g[c]);
      end
      push(exp_g[c], (c < 4) ? 16'd30 : 16'd31);
    end
  endtask

  task automatic test_lock_hold();
    logic [NC-1:0] rq[5];
    logic [NC-1:0] lk[5];
    logic [NC-1:0] eg[5];
    rq = '{4'b0010, 4'b1000, 4'b1000, 4'b1010, 4'b1000};
    lk = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    eg = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b1000};
    do_reset();
    bus.addr = {16'd43, 16'd42, 16'd41, 16'd40};
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      bus.req  = rq[c];
      bus.lock = lk[c];
      @(negedge clk);
      n_run++;
      if (bus.gnt !== eg[c]) begin
        n_fail++; $display("FAIL lock_hold c=%0d got=%b exp=%b", c, bus.gnt, eg[c]);
      end
      if (eg[c] != '0) push(eg[c], (eg[c] == 4'b1000) ? 16'd43 : 16'd41);
    end
  endtask

  task automatic test_lock_nonowner();
    logic [NC-1:0] eg[3];
    eg = '{4'b0001, 4'b0010, 4'b0001};
    do_reset();
    bus.addr = {16'd53, 16'd52, 16'd51, 16'd50};
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      bus.req  = 4'b0011;
      bus.lock = 4'b0100;
      @(negedge clk);
      n_run++;
      if (bus.gnt !== eg[c]) begin
        n_fail++; $display("FAIL lock_nonowner c=%0d got=%b exp=%b", c, bus.gnt, eg[c]);
      end
      push(eg[c], (eg[c] == 4'b0001) ? 16'd50 : 16'd51);
    end
    bus.lock = '0;
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    bus.addr = {16'd63, 16'd62, 16'd61, 16'd60};
    next_cycle();
    bus.req = 4'b0100;
    @(negedge clk);
    n_run++;
    if (bus.gnt !== 4'b0100) begin
      n_fail++; $display("FAIL midfetch_gnt got=%b exp=0100", bus.gnt);
    end
    push(4'b0100, 16'd62);
    next_cycle();
    reset   = 1'b1;
    bus.req = 4'b1010;
    sb.delete();
    @(negedge clk);
    n_run += 3;
    if (bus.gnt !== '0) begin
      n_fail++; $display("FAIL midfetch_rst_gnt got=%b exp=0", bus.gnt);
    end
    if (bus.rvalid !== '0) begin
      n_fail++; $display("FAIL midfetch_rvalid got=%b exp=0", bus.rvalid);
    end
    if (bus.fetch_count !== 16'd0) begin
      n_fail++; $display("FAIL midfetch_count got=%0d exp=0", bus.fetch_count);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_run++;
    if (bus.gnt !== 4'b0010) begin
      n_fail++; $display("FAIL midfetch_after got=%b exp=0010", bus.gnt);
    end
    push(4'b0010, 16'd61);
  endtask

  task automatic test_saturation();
    do_reset();
    bus.addr = {16'd73, 16'd72, 16'd71, 16'd70};
    for (int c = 0; c < 65534; c++) begin
      next_cycle();
      bus.req = 4'b0001;
      @(negedge clk);
      push(4'b0001, 16'd70);
    end
    next_cycle();
    bus.req = '0;
    @(negedge clk);
    n_run++;
    if (bus.fetch_count !== 16'hFFFE) begin
      n_fail++; $display("FAIL sat_near got=%h exp=fffe", bus.fetch_count);
    end
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      bus.req = 4'b0001;
      @(negedge clk);
      push(4'b0001, 16'd70);
    end
    next_cycle();
    bus.req = '0;
    @(negedge clk);
    n_run++;
    if (bus.fetch_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold got=%h exp=ffff", bus.fetch_count);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_fetch();
    test_lock_max();
    test_lock_hold();
    test_lock_nonowner();
    test_reset_midfetch();
    test_saturation();
    next_cycle();
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    n_run++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
